// File: rtl/demux_pkg.sv
// Shared types and constants for the 1x2 time-division demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_0 = 2'd1,
    HAVE_1 = 2'd2
  } pair_state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/four_bit_1x2_demux_if.sv
// Bus-side and result-side signals of the demux, grouped for port reuse.
interface four_bit_1x2_demux_if #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned COUNT_WIDTH = 8
);
  logic [WIDTH-1:0]       In;
  logic                   Select;
  logic                   In_Valid;
  logic                   Clear_Overrun;
  logic [WIDTH-1:0]       Out_0;
  logic [WIDTH-1:0]       Out_1;
  logic                   Out_0_Valid;
  logic                   Out_1_Valid;
  logic [2*WIDTH-1:0]     Pair_Out;
  logic                   Pair_Valid;
  logic                   Overrun;
  logic [COUNT_WIDTH-1:0] Pair_Count;

  modport master (
    output In, Select, In_Valid, Clear_Overrun,
    input  Out_0, Out_1, Out_0_Valid, Out_1_Valid,
    input  Pair_Out, Pair_Valid, Overrun, Pair_Count
  );

  modport slave (
    input  In, Select, In_Valid, Clear_Overrun,
    output Out_0, Out_1, Out_0_Valid, Out_1_Valid,
    output Pair_Out, Pair_Valid, Overrun, Pair_Count
  );
endinterface

// File: rtl/channel_hold_reg.sv
// Load-enabled word register that holds its value and pulses valid on each load.
module channel_hold_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      if (load) q <= d;
      q_valid <= load;
    end
  end

endmodule

// File: rtl/four_bit_1x2_demux.sv
// Registered 1x2 demux: routes tagged bus words to held channel outputs and
// pairs one ch0 with one ch1 word, flagging repeated-channel overruns.
module four_bit_1x2_demux
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input logic                 Clock,
  input logic                 Reset_n,
  four_bit_1x2_demux_if.slave bus
);

  pair_state_t            state_q, state_d;
  logic [2*WIDTH-1:0]     pair_q, pair_d;
  logic                   pair_valid_q, pair_valid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic                   overrun_set;
  logic [WIDTH-1:0]       out_0, out_1;
  logic                   out_0_valid, out_1_valid;
  logic                   load_0, load_1;

  assign load_0 = bus.In_Valid && (bus.Select == CH0);
  assign load_1 = bus.In_Valid && (bus.Select == CH1);

  channel_hold_reg #(.WIDTH(WIDTH)) u_hold_0 (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .load    (load_0),
    .d       (bus.In),
    .q       (out_0),
    .q_valid (out_0_valid)
  );

  channel_hold_reg #(.WIDTH(WIDTH)) u_hold_1 (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .load    (load_1),
    .d       (bus.In),
    .q       (out_1),
    .q_valid (out_1_valid)
  );

  // While a partial pair is pending, the waiting word is the one held on its channel output.
  always_comb begin
    state_d      = state_q;
    pair_d       = pair_q;
    pair_valid_d = 1'b0;
    count_d      = count_q;
    overrun_set  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (load_0) state_d = HAVE_0;
        else if (load_1) state_d = HAVE_1;
      end
      HAVE_0: begin
        if (load_1) begin
          pair_d       = {bus.In, out_0};
          pair_valid_d = 1'b1;
          count_d      = count_q + COUNT_WIDTH'(1);
          state_d      = EMPTY;
        end else if (load_0) begin
          overrun_set = 1'b1;
        end
      end
      HAVE_1: begin
        if (load_0) begin
          pair_d       = {out_1, bus.In};
          pair_valid_d = 1'b1;
          count_d      = count_q + COUNT_WIDTH'(1);
          state_d      = EMPTY;
        end else if (load_1) begin
          overrun_set = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    overrun_d = overrun_set | (overrun_q & ~bus.Clear_Overrun);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q      <= EMPTY;
      pair_q       <= '0;
      pair_valid_q <= 1'b0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pair_q       <= pair_d;
      pair_valid_q <= pair_valid_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.Out_0       = out_0;
  assign bus.Out_1       = out_1;
  assign bus.Out_0_Valid = out_0_valid;
  assign bus.Out_1_Valid = out_1_valid;
  assign bus.Pair_Out    = pair_q;
  assign bus.Pair_Valid  = pair_valid_q;
  assign bus.Overrun     = overrun_q;
  assign bus.Pair_Count  = count_q;

endmodule

// File: tb/tb_four_bit_1x2_demux.sv
// Random and directed checks of four_bit_1x2_demux against a pending-word model;
// a second instance with a 2-bit counter exercises counter wrap.
module tb_four_bit_1x2_demux;

  logic clk;
  logic rst_n;

  four_bit_1x2_demux_if #(.WIDTH(4), .COUNT_WIDTH(8)) bus8 ();
  four_bit_1x2_demux_if #(.WIDTH(4), .COUNT_WIDTH(2)) bus2 ();

  four_bit_1x2_demux #(.WIDTH(4), .COUNT_WIDTH(8)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus8)
  );

  four_bit_1x2_demux #(.WIDTH(4), .COUNT_WIDTH(2)) dut_w2 (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: each channel either has a word waiting for its partner or not.
  logic [3:0] m_out   [2];
  logic       m_vld   [2];
  logic [3:0] m_held  [2];
  bit         m_wait  [2];
  logic [7:0] m_pair;
  logic       m_pair_v;
  logic       m_ov;
  int         m_pairs;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic s,
                            input logic [3:0] d, input logic clr);
    bit ov_set;
    int ch;
    int other;
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        m_out[i] = '0; m_vld[i] = 1'b0; m_held[i] = '0; m_wait[i] = 0;
      end
      m_pair = '0; m_pair_v = 1'b0; m_ov = 1'b0; m_pairs = 0;
      return;
    end
    ov_set   = 0;
    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
    m_pair_v = 1'b0;
    if (v) begin
      ch        = s ? 1 : 0;
      other     = 1 - ch;
      m_out[ch] = d;
      m_vld[ch] = 1'b1;
      if (m_wait[other]) begin
        m_pair       = (ch == 1) ? {d, m_held[0]} : {m_held[1], d};
        m_pair_v     = 1'b1;
        m_pairs      = m_pairs + 1;
        m_wait[other] = 0;
      end else begin
        if (m_wait[ch]) ov_set = 1;
        m_wait[ch] = 1;
        m_held[ch] = d;
      end
    end
    if (ov_set) m_ov = 1'b1;
    else if (clr) m_ov = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("out_0",       32'(bus8.Out_0),       32'(m_out[0]));
    check_eq("out_1",       32'(bus8.Out_1),       32'(m_out[1]));
    check_eq("out_0_valid", 32'(bus8.Out_0_Valid), 32'(m_vld[0]));
    check_eq("out_1_valid", 32'(bus8.Out_1_Valid), 32'(m_vld[1]));
    check_eq("pair_out",    32'(bus8.Pair_Out),    32'(m_pair));
    check_eq("pair_valid",  32'(bus8.Pair_Valid),  32'(m_pair_v));
    check_eq("overrun",     32'(bus8.Overrun),     32'(m_ov));
    check_eq("pair_count",  32'(bus8.Pair_Count),  32'(m_pairs % 256));
    check_eq("pair_count_w2", 32'(bus2.Pair_Count), 32'(m_pairs % 4));
    check_eq("pair_out_w2",   32'(bus2.Pair_Out),   32'(m_pair));
  endtask

  // Drive one cycle of stimulus to both instances, advance the model, and compare.
  task automatic cycle(input logic r, input logic v, input logic s,
                       input logic [3:0] d, input logic clr);
    rst_n              = r;
    bus8.In_Valid      = v;  bus2.In_Valid      = v;
    bus8.Select        = s;  bus2.Select        = s;
    bus8.In            = d;  bus2.In            = d;
    bus8.Clear_Overrun = clr; bus2.Clear_Overrun = clr;
    @(posedge clk);
    model_step(r, v, s, d, clr);
    #1;
    compare_all();
  endtask

  task automatic beat(input logic s, input logic [3:0] d);
    cycle(1'b1, 1'b1, s, d, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.In = '0; bus8.Select = 1'b0; bus8.In_Valid = 1'b0; bus8.Clear_Overrun = 1'b0;
    bus2.In = '0; bus2.Select = 1'b0; bus2.In_Valid = 1'b0; bus2.Clear_Overrun = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

    // Reset holds everything at zero even with a beat presented.
    cycle(1'b0, 1'b1, 1'b1, 4'hF, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 4'hF, 1'b0);
    check_eq("rst_out_1", 32'(bus8.Out_1), 32'h0);

    // Ordered pair.
    beat(1'b0, 4'h3);
    check_eq("ord_out_0", 32'(bus8.Out_0), 32'h3);
    check_eq("ord_no_pair", 32'(bus8.Pair_Valid), 32'h0);
    beat(1'b1, 4'hA);
    check_eq("ord_pair", 32'(bus8.Pair_Out), 32'hA3);
    check_eq("ord_count", 32'(bus8.Pair_Count), 32'h1);
    idle();
    check_eq("ord_pulse_once", 32'(bus8.Pair_Valid), 32'h0);

    // Reversed pair with idle gap.
    beat(1'b1, 4'h5);
    repeat (3) idle();
    beat(1'b0, 4'hC);
    check_eq("rev_pair", 32'(bus8.Pair_Out), 32'h5C);
    check_eq("rev_no_ovr", 32'(bus8.Overrun), 32'h0);

    // Overrun, then clear, then clear colliding with a new overrun.
    beat(1'b0, 4'h1);
    beat(1'b0, 4'h2);
    check_eq("ovr_set", 32'(bus8.Overrun), 32'h1);
    beat(1'b1, 4'h7);
    check_eq("ovr_pair", 32'(bus8.Pair_Out), 32'h72);
    check_eq("ovr_count", 32'(bus8.Pair_Count), 32'h3);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    check_eq("ovr_clear", 32'(bus8.Overrun), 32'h0);
    beat(1'b1, 4'h4);
    cycle(1'b1, 1'b1, 1'b1, 4'h6, 1'b1);
    check_eq("ovr_set_wins", 32'(bus8.Overrun), 32'h1);
    beat(1'b0, 4'h8);

    // Fourth pair wraps the 2-bit counter.
    check_eq("wrap_w2", 32'(bus2.Pair_Count), 32'h0);

    // Reset mid-pair discards the waiting word; the next ch1 beat starts a fresh pair.
    beat(1'b0, 4'h9);
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    beat(1'b1, 4'h4);
    check_eq("mid_rst_no_pair", 32'(bus8.Pair_Valid), 32'h0);
    beat(1'b0, 4'h6);
    check_eq("mid_rst_have_1", 32'(bus8.Pair_Out), 32'h46);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, v, s, clr;
      logic [3:0] d;
      r   = ($urandom_range(0, 511) != 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = 1'($urandom_range(0, 1));
      d   = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0);
      cycle(r, v, s, d, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
